mem_bus_ctrl: RTL and testbench

- Memory/bus controller directly downstream of the CPU core. Consumes the core's addr/out_data/memory_w and returns in_data plus the memory_ready handshake.
- Decodes each access to either on-chip synchronous-read RAM or a small MMIO window (LEDs, switches, UART TX, status).
- Inserts configurable wait states.

---
 rtl/mem_bus_ctrl_pkg.sv | 34 +++
 rtl/mem_bus_ctrl_mmio.sv | 68 ++++++
 rtl/mem_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared memory map, FSM state encodings and address-decode helpers for the
// CPU-side memory/bus controller.
package mem_bus_ctrl_pkg;

  // MMIO register addresses (word addresses)
  localparam logic [15:0] IO_LED   = 16'h0000;
  localparam logic [15:0] IO_SW    = 16'h0001;
  localparam logic [15:0] IO_TX    = 16'h0002;
  localparam logic [15:0] IO_STAT  = 16'h0003;
  localparam logic [15:0] RAM_BASE = 16'h0010;

  // Controller FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RAM_ACC  = 3'd1;
  localparam logic [2:0] ST_RAM_WAIT = 3'd2;
  localparam logic [2:0] ST_IO       = 3'd3;
  localparam logic [2:0] ST_TX_WAIT  = 3'd4;
  localparam logic [2:0] ST_READY    = 3'd5;
  localparam logic [2:0] ST_RECOVER  = 3'd6;

  // Anything at or above RAM_BASE is backed by the on-chip RAM.
  function automatic logic is_ram_addr(input logic [15:0] addr);
    return (addr >= RAM_BASE);
  endfunction

  // Accesses that complete normally but flag a bus error: any access to the
  // unmapped hole, or a write to the read-only switch register.
  function automatic logic is_io_err(input logic [15:0] addr, input logic we);
    logic unmapped;
    unmapped = (addr >= 16'h0004) && (addr < RAM_BASE);
    return unmapped || (we && (addr == IO_SW));
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_mmio.sv
// MMIO register block: LED register, sticky bus error flag, status read mux
// and error decode. Updates happen on the single cycle io_en_i is high.
module mem_bus_ctrl_mmio
  import mem_bus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_en_i,
  input  logic [15:0] addr_i,
  input  logic        we_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] sw_i,
  input  logic        tx_ready_i,
  output logic [15:0] led_o,
  output logic        bus_err_o,
  output logic [15:0] rdata_o
);

  logic [15:0] led_q, led_d;
  logic        bus_err_q, bus_err_d;

  // Next-state for LED and bus_err; error decode wins, W1C only via status bit1.
  always_comb begin
    led_d     = led_q;
    bus_err_d = bus_err_q;
    if (io_en_i) begin
      if (is_io_err(addr_i, we_i)) begin
        bus_err_d = 1'b1;
      end else if (we_i && (addr_i == IO_LED)) begin
        led_d = wdata_i;
      end else if (we_i && (addr_i == IO_STAT) && wdata_i[1]) begin
        bus_err_d = 1'b0;
      end else begin
        led_d     = led_q;
        bus_err_d = bus_err_q;
      end
    end else begin
      led_d     = led_q;
      bus_err_d = bus_err_q;
    end
  end

  // Register read mux; TX data, unmapped and error reads all return zero.
  always_comb begin
    rdata_o = 16'h0000;
    case (addr_i)
      IO_LED:  rdata_o = led_q;
      IO_SW:   rdata_o = sw_i;
      IO_STAT: rdata_o = {14'b0, bus_err_q, tx_ready_i};
      default: rdata_o = 16'h0000;
    endcase
  end

  // MMIO register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 16'h0000;
      bus_err_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign led_o     = led_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory/bus controller between the CPU core and on-chip RAM / MMIO.
// Samples the always-present CPU request in IDLE, runs one access to
// completion, pulses cpu_ready for one cycle, then idles one dead cycle.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW      = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  input  logic              cpu_we,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  input  logic [15:0]       sw_i,
  output logic [15:0]       led_o,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              bus_err
);

  logic [2:0]        state_q, state_d;
  logic [15:0]       req_addr_q, req_addr_d;
  logic [15:0]       req_wdata_q, req_wdata_d;
  logic              req_we_q, req_we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [15:0]       cpu_rdata_q, cpu_rdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [15:0]       tx_data_q, tx_data_d;
  logic              io_en_s;
  logic [15:0]       mmio_rdata_s;

  assign io_en_s = (state_q == ST_IO);

  mem_bus_ctrl_mmio u_mmio (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_en_i    (io_en_s),
    .addr_i     (req_addr_q),
    .we_i       (req_we_q),
    .wdata_i    (req_wdata_q),
    .sw_i       (sw_i),
    .tx_ready_i (tx_ready),
    .led_o      (led_o),
    .bus_err_o  (bus_err),
    .rdata_o    (mmio_rdata_s)
  );

  // FSM next-state; RAM strobe and TX request are set up on the edge leaving
  // IDLE so they are registered and valid for exactly the intended cycles.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_we_d    = req_we_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        req_addr_d  = cpu_addr;
        req_wdata_d = cpu_wdata;
        req_we_d    = cpu_we;
        if (is_ram_addr(cpu_addr)) begin
          ram_addr_d  = cpu_addr[RAM_AW-1:0];
          ram_wdata_d = cpu_wdata;
          ram_we_d    = cpu_we;
          state_d     = ST_RAM_ACC;
        end else if ((cpu_addr == IO_TX) && cpu_we) begin
          tx_valid_d = 1'b1;
          tx_data_d  = cpu_wdata;
          state_d    = ST_TX_WAIT;
        end else begin
          state_d = ST_IO;
        end
      end
      ST_RAM_ACC: begin
        cnt_d   = 4'(WAIT_STATES);
        state_d = ST_RAM_WAIT;
      end
      ST_RAM_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!req_we_q) begin
            cpu_rdata_d = ram_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          cpu_ready_d = 1'b1;
          state_d     = ST_READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_IO: begin
        if (!req_we_q) begin
          cpu_rdata_d = mmio_rdata_s;
        end else begin
          cpu_rdata_d = cpu_rdata_q;
        end
        cpu_ready_d = 1'b1;
        state_d     = ST_READY;
      end
      ST_TX_WAIT: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d  = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = ST_READY;
        end else begin
          state_d = ST_TX_WAIT;
        end
      end
      ST_READY: begin
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Controller state and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= 16'h0000;
      req_wdata_q <= 16'h0000;
      req_we_q    <= 1'b0;
      cnt_q       <= 4'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 16'h0000;
      ram_we_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 16'h0000;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_we_q    <= req_we_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl: one instance with no wait
// states (full access mix, TX handshake, errors, reset mid-TX) and one with
// WAIT_STATES=3 for the wait-state latency.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (WAIT_STATES = 0)
  logic        rst_n;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_ready;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic [15:0] sw, led, tx_data;
  logic        tx_valid, tx_ready, bus_err;

  // Instance B (WAIT_STATES = 3)
  logic        rst_n_b;
  logic [15:0] cpu_addr_b, cpu_wdata_b, cpu_rdata_b;
  logic        cpu_we_b, cpu_ready_b;
  logic [15:0] ram_addr_b, ram_wdata_b, ram_rdata_b;
  logic        ram_we_b;
  logic [15:0] sw_b, led_b, tx_data_b;
  logic        tx_valid_b, tx_ready_b, bus_err_b;

  mem_bus_ctrl #(.RAM_AW(16), .WAIT_STATES(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .sw_i(sw), .led_o(led), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .bus_err(bus_err)
  );

  mem_bus_ctrl #(.RAM_AW(16), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b), .cpu_we(cpu_we_b),
    .cpu_rdata(cpu_rdata_b), .cpu_ready(cpu_ready_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_rdata(ram_rdata_b),
    .sw_i(sw_b), .led_o(led_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .bus_err(bus_err_b)
  );

  // Synchronous-read RAM behind instance A
  logic [15:0] mem_a [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_addr] <= ram_wdata;
    ram_rdata <= mem_a[ram_addr];
  end

  // Instance B RAM: read-only pattern derived from the address, 1-cycle latency
  always @(posedge clk) begin
    ram_rdata_b <= ram_addr_b ^ 16'h4110;
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q [$];
  logic [15:0] mem_m [logic [15:0]];
  logic [15:0] led_m;
  logic        bus_err_m;
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a >= 16'h0010) return mem_m[a];
    else if (a == 16'h0000) return led_m;
    else if (a == 16'h0001) return sw;
    else if (a == 16'h0003) return {14'b0, bus_err_m, tx_ready};
    else return 16'h0000;
  endfunction

  // One CPU access on instance A; the DUT must be in IDLE at the next posedge.
  task automatic access(input string tag, input logic [15:0] addr, input logic we,
                        input logic [15:0] wdata, input int exp_lat, input int tx_delay);
    int          n;
    int          we_cnt;
    int          hs;
    int          vcyc;
    logic        done;
    logic [15:0] we_addr, we_data, txd;
    @(negedge clk);
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_wdata = wdata;
    if (tx_delay > 0) tx_ready = 1'b0;
    if (!we) last_rd = model_read(addr);
    sb_q.push_back(last_rd);
    if (we) begin
      if (addr >= 16'h0010) mem_m[addr] = wdata;
      else if (addr == 16'h0000) led_m = wdata;
      else if (addr == 16'h0003) begin
        if (wdata[1]) bus_err_m = 1'b0;
      end
      else if (addr != 16'h0002) bus_err_m = 1'b1;
    end else if (addr >= 16'h0004 && addr < 16'h0010) begin
      bus_err_m = 1'b1;
    end
    n = 0; we_cnt = 0; hs = 0; vcyc = 0; done = 1'b0;
    we_addr = 16'h0000; we_data = 16'h0000; txd = 16'h0000;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        cpu_addr  = addr ^ 16'h0F0F;
        cpu_we    = ~we;
        cpu_wdata = ~wdata;
      end
      if (ram_we) begin we_cnt++; we_addr = ram_addr; we_data = ram_wdata; end
      if (tx_delay > 0 && n == tx_delay) tx_ready = 1'b1;
      if (tx_valid) begin vcyc++; txd = tx_data; if (tx_ready) hs++; end
      if (cpu_ready) done = 1'b1;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " rdata"}, cpu_rdata, sb_q.pop_front());
    chk({tag, " ram_we count"}, we_cnt, (we && addr >= 16'h0010) ? 1 : 0);
    if (we && addr >= 16'h0010) begin
      chk({tag, " ram_addr"}, we_addr, addr);
      chk({tag, " ram_wdata"}, we_data, wdata);
    end
    if (tx_delay > 0) begin
      chk({tag, " handshakes"}, hs, 1);
      chk({tag, " tx_valid cycles"}, vcyc, tx_delay);
      chk({tag, " tx_data"}, txd, wdata);
    end
    chk({tag, " led"}, led, led_m);
    chk({tag, " bus_err"}, bus_err, bus_err_m);
    @(posedge clk); #1;
    chk({tag, " single ready pulse"}, cpu_ready, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   n;
    int   pulses;
    int   web;
    logic done;
    rst_n = 1'b0; rst_n_b = 1'b0;
    cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_wdata = 16'h0000;
    tx_ready = 1'b1; sw = 16'h5A5A;
    cpu_addr_b = 16'hFFFF; cpu_we_b = 1'b0; cpu_wdata_b = 16'h0000;
    sw_b = 16'h0000; tx_ready_b = 1'b0;
    led_m = 16'h0000; bus_err_m = 1'b0; last_rd = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst cpu_ready", cpu_ready, 1'b0);
    chk("rst cpu_rdata", cpu_rdata, 16'h0000);
    chk("rst ram_we", ram_we, 1'b0);
    chk("rst ram_addr", ram_addr, 16'h0000);
    chk("rst ram_wdata", ram_wdata, 16'h0000);
    chk("rst led", led, 16'h0000);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 16'h0000);
    chk("rst bus_err", bus_err, 1'b0);
    rst_n = 1'b1;

    access("ram_wr",   16'h0100, 1'b1, 16'h1234, 3, 0);
    access("ram_rd",   16'h0100, 1'b0, 16'h0000, 3, 0);
    access("ram_wr2",  16'hFFF0, 1'b1, 16'hCAFE, 3, 0);
    access("ram_rd2",  16'hFFF0, 1'b0, 16'h0000, 3, 0);
    access("led_wr",   16'h0000, 1'b1, 16'h00A5, 2, 0);
    access("sw_rd",    16'h0001, 1'b0, 16'h0000, 2, 0);
    access("led_rd",   16'h0000, 1'b0, 16'h0000, 2, 0);
    access("tx_wr",    16'h0002, 1'b1, 16'h0041, 11, 10);
    access("tx_rd",    16'h0002, 1'b0, 16'h0000, 2, 0);
    access("unmap_wr", 16'h0005, 1'b1, 16'h1111, 2, 0);
    access("stat_rd",  16'h0003, 1'b0, 16'h0000, 2, 0);
    access("unmap_rd", 16'h000F, 1'b0, 16'h0000, 2, 0);
    access("stat_clr", 16'h0003, 1'b1, 16'h0002, 2, 0);
    access("stat_rd2", 16'h0003, 1'b0, 16'h0000, 2, 0);
    access("sw_wr",    16'h0001, 1'b1, 16'hFFFF, 2, 0);

    // Reset while stalled in TX_WAIT with LED set and bus_err raised
    @(negedge clk);
    cpu_addr = 16'h0002; cpu_we = 1'b1; cpu_wdata = 16'h0055; tx_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midtx tx_valid", tx_valid, 1'b1);
    chk("midtx tx_data", tx_data, 16'h0055);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst tx_valid", tx_valid, 1'b0);
    chk("async rst cpu_ready", cpu_ready, 1'b0);
    chk("async rst led", led, 16'h0000);
    chk("async rst bus_err", bus_err, 1'b0);
    chk("async rst cpu_rdata", cpu_rdata, 16'h0000);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    led_m = 16'h0000; bus_err_m = 1'b0; last_rd = 16'h0000;
    access("post_rst_rd", 16'h0100, 1'b0, 16'h0000, 3, 0);

    // Wait-state instance: read 0xFFFF, expect 6-cycle latency and one pulse
    chk("B rst ram_addr", ram_addr_b, 16'h0000);
    @(negedge clk);
    rst_n_b = 1'b1;
    n = 0; pulses = 0; web = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) cpu_addr_b = 16'h0010;
      if (ram_we_b) web++;
      if (cpu_ready_b) begin pulses++; done = 1'b1; end
    end
    chk("B latency", n, 6);
    chk("B rdata", cpu_rdata_b, 16'hBEEF);
    chk("B ram_addr", ram_addr_b, 16'hFFFF);
    @(posedge clk); #1;
    if (cpu_ready_b) pulses++;
    chk("B ready pulses", pulses, 1);
    chk("B ram_we", web, 0);
    chk("B ram_wdata", ram_wdata_b, 16'h0000);
    chk("B bus_err", bus_err_b, 1'b0);
    chk("B tx_valid", tx_valid_b, 1'b0);
    chk("B led", led_b, 16'h0000);
    chk("B tx_data", tx_data_b, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
